// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one combinational fp32 adder among N_REQ requesters.
// One operation in flight; special operands are screened before the normal-number core.
module fp_add_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] id_q;
  logic [31:0]     opa;
  logic [31:0]     opb;

  // ---------------- arbitration ----------------
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_en;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_sub;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = ID_W'((32'(last) + k) % NR);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  // Gated by rst_n so req_ready reads zero while reset is held.
  assign grant_en  = rst_n && grant_found &&
                     ((state == IDLE) || ((state == HOLD) && rsp_ready));
  assign req_ready = grant_en ? (N_REQ'(1) << grant_idx) : '0;

  // ---------------- operand decode ----------------
  logic       sa, sb;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb;
  logic       a_nan, b_nan, a_inf, b_inf;

  assign sa    = opa[31];
  assign sb    = opb[31];
  assign ea    = opa[30:23];
  assign eb    = opb[30:23];
  assign fa    = opa[22:0];
  assign fb    = opb[22:0];
  assign a_nan = (ea == 8'hFF) && (fa != '0);
  assign b_nan = (eb == 8'hFF) && (fb != '0);
  assign a_inf = (ea == 8'hFF) && (fa == '0);
  assign b_inf = (eb == 8'hFF) && (fb == '0);

  // ---------------- normal-number core ----------------
  logic        swap;
  logic        s_big;
  logic        eff_sub;
  logic [7:0]  e_big, e_small, e_diff;
  logic [23:0] m_big, m_small;
  logic [53:0] sh_full;
  logic [26:0] m_al;
  logic [27:0] sum_raw;
  logic [4:0]  lz;
  logic        lz_found;
  logic [26:0] m_n;
  logic [9:0]  e_n;
  logic        rnd_up;
  logic [24:0] mant;
  logic [9:0]  e_r;
  logic [22:0] frac_r;
  logic [31:0] core_out;

  assign swap    = {eb, fb} > {ea, fa};
  assign s_big   = swap ? sb : sa;
  assign eff_sub = sa ^ sb;
  assign e_big   = swap ? eb : ea;
  assign e_small = swap ? ea : eb;
  assign m_big   = swap ? {1'b1, fb} : {1'b1, fa};
  assign m_small = swap ? {1'b1, fa} : {1'b1, fb};
  assign e_diff  = e_big - e_small;

  // Align the smaller operand; bits shifted past the round position collapse into sticky.
  always_comb begin
    sh_full = '0;
    if (e_diff > 8'd26) begin
      m_al = 27'd1;
    end else begin
      sh_full = {m_small, 30'b0} >> e_diff;
      m_al    = sh_full[53:27] | {26'b0, |sh_full[26:0]};
    end
  end

  assign sum_raw = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, m_al})
                           : ({1'b0, m_big, 3'b000} + {1'b0, m_al});

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!lz_found && sum_raw[26-i]) begin
        lz       = 5'(i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (sum_raw[27]) begin
      m_n = {sum_raw[27:2], sum_raw[1] | sum_raw[0]};
      e_n = 10'(e_big) + 10'd1;
    end else begin
      m_n = sum_raw[26:0] << lz;
      e_n = 10'(e_big) - 10'(lz);
    end
  end

  // Round to nearest even on guard/round/sticky; a mantissa carry bumps the exponent.
  assign rnd_up = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
  assign mant   = {1'b0, m_n[26:3]} + 25'(rnd_up);
  assign e_r    = e_n + 10'(mant[24]);
  assign frac_r = mant[24] ? mant[23:1] : mant[22:0];

  always_comb begin
    if (e_n[9] || (e_n == '0))
      core_out = {s_big, 31'b0};
    else if (e_r >= 10'd255)
      core_out = {s_big, 8'hFF, 23'b0};
    else
      core_out = {s_big, e_r[7:0], frac_r};
  end

  // ---------------- special-value screening ----------------
  logic [31:0] result;

  always_comb begin
    if ((ea == 8'hFF) || (eb == 8'hFF)) begin
      if (a_nan || b_nan)
        result = 32'h7FC0_0000;
      else if (a_inf && b_inf && (sa != sb))
        result = 32'h7FC0_0000;
      else
        result = a_inf ? opa : opb;
    end else if ((ea == 8'h00) && (eb == 8'h00)) begin
      result = {sa & sb, 31'b0};
    end else if (ea == 8'h00) begin
      result = opb;
    end else if (eb == 8'h00) begin
      result = opa;
    end else if ((sa != sb) && (opa[30:0] == opb[30:0])) begin
      result = '0;
    end else begin
      result = core_out;
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      opa       <= '0;
      opb       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            opa   <= sel_a;
            opb   <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
            id_q  <= grant_idx;
            last  <= grant_idx;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            if (grant_en) begin
              opa   <= sel_a;
              opb   <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
              id_q  <= grant_idx;
              last  <= grant_idx;
              state <= EXEC;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
